// File: rtl/irq_gateway_arbiter_if.sv
// Bundles the source, configuration, claim/complete and core-request signals of irq_gateway_arbiter.
// The master modport drives sources, configuration and software requests; the slave modport is the gateway.
interface irq_gateway_arbiter_if #(
    parameter int NUM_SRC = 16,
    parameter int PRIO_W  = 3,
    parameter int NUM_TGT = 2
);
    localparam int ID_W      = $clog2(NUM_SRC + 1);
    localparam int SRC_IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int TGT_IDX_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;

    logic [NUM_SRC-1:0]        irq_src_i;
    logic                      prio_we_i;
    logic [SRC_IDX_W-1:0]      prio_idx_i;
    logic [PRIO_W-1:0]         prio_i;
    logic                      en_we_i;
    logic [TGT_IDX_W-1:0]      en_tgt_i;
    logic [NUM_SRC-1:0]        en_mask_i;
    logic [NUM_TGT*PRIO_W-1:0] thresh_i;
    logic [NUM_TGT-1:0]        claim_req_i;
    logic [NUM_TGT-1:0]        claim_valid_o;
    logic [NUM_TGT*ID_W-1:0]   claim_id_o;
    logic                      cmpl_valid_i;
    logic [ID_W-1:0]           cmpl_id_i;
    logic [NUM_TGT-1:0]        irq_o;

    modport master (
        output irq_src_i, prio_we_i, prio_idx_i, prio_i, en_we_i, en_tgt_i, en_mask_i,
               thresh_i, claim_req_i, cmpl_valid_i, cmpl_id_i,
        input  claim_valid_o, claim_id_o, irq_o
    );

    modport slave (
        input  irq_src_i, prio_we_i, prio_idx_i, prio_i, en_we_i, en_tgt_i, en_mask_i,
               thresh_i, claim_req_i, cmpl_valid_i, cmpl_id_i,
        output claim_valid_o, claim_id_o, irq_o
    );
endinterface

// File: rtl/irq_gateway_arbiter.sv
// PLIC-style interrupt gateway and per-target priority arbiter feeding the core's M/S irq inputs.
// Define IRQ_GATEWAY_EDGE_EN for edge-triggered sources; level-triggered otherwise.
module irq_gateway_arbiter #(
    parameter int NUM_SRC = 16,
    parameter int PRIO_W  = 3,
    parameter int NUM_TGT = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    irq_gateway_arbiter_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_SRC + 1);

    typedef enum logic [1:0] {
        GW_IDLE    = 2'd0,
        GW_PENDING = 2'd1,
        GW_CLAIMED = 2'd2
    } gw_state_e;

    gw_state_e                 gw_q [NUM_SRC];
    gw_state_e                 gw_d [NUM_SRC];
    logic [PRIO_W-1:0]         prio_q [NUM_SRC];
    logic [NUM_SRC-1:0]        en_q [NUM_TGT];
    logic [ID_W-1:0]           best_q [NUM_TGT];
    logic [ID_W-1:0]           best_d [NUM_TGT];
    logic [ID_W-1:0]           grant_id [NUM_TGT];
    logic [NUM_TGT-1:0]        irq_q;
    logic [NUM_TGT-1:0]        claim_valid_q;
    logic [NUM_TGT*ID_W-1:0]   claim_id_q;
    logic [NUM_SRC-1:0]        claimed_now;
    logic [NUM_SRC-1:0]        cmpl_hit;
    logic [NUM_SRC-1:0]        trig;

`ifdef IRQ_GATEWAY_EDGE_EN
    logic [NUM_SRC-1:0] src_prev_q;
    logic [NUM_SRC-1:0] sticky_q;
    logic [NUM_SRC-1:0] sticky_d;

    assign trig = bus.irq_src_i & ~src_prev_q;
`else
    assign trig = bus.irq_src_i;
`endif

    // Claims resolve in target order, so a lower target takes a shared winner and the rest read 0.
    always_comb begin
        claimed_now = '0;
        for (int t = 0; t < NUM_TGT; t++) begin
            grant_id[t] = '0;
            if (bus.claim_req_i[t]) begin
                for (int s = 0; s < NUM_SRC; s++) begin
                    if (best_q[t] == ID_W'(s + 1) && !claimed_now[s]) begin
                        grant_id[t]    = best_q[t];
                        claimed_now[s] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            cmpl_hit[s] = bus.cmpl_valid_i && (bus.cmpl_id_i == ID_W'(s + 1));
        end
    end

    // Sources being claimed this cycle are masked so best_q never offers an already-taken ID.
    always_comb begin
        logic [PRIO_W-1:0] best_prio;
        for (int t = 0; t < NUM_TGT; t++) begin
            best_d[t] = '0;
            best_prio = '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (gw_q[s] == GW_PENDING && !claimed_now[s] && en_q[t][s] &&
                    prio_q[s] > bus.thresh_i[t*PRIO_W +: PRIO_W] && prio_q[s] > best_prio) begin
                    best_d[t] = ID_W'(s + 1);
                    best_prio = prio_q[s];
                end
            end
        end
    end

    // NOTE: every combinational output gets a default before the case so no latch is inferred.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            gw_d[s] = gw_q[s];
`ifdef IRQ_GATEWAY_EDGE_EN
            sticky_d[s] = sticky_q[s];
`endif
            unique case (gw_q[s])
                GW_IDLE:    if (trig[s]) gw_d[s] = GW_PENDING;
                GW_PENDING: if (claimed_now[s]) gw_d[s] = GW_CLAIMED;
                GW_CLAIMED: begin
                    if (cmpl_hit[s]) begin
`ifdef IRQ_GATEWAY_EDGE_EN
                        gw_d[s]     = (sticky_q[s] || trig[s]) ? GW_PENDING : GW_IDLE;
                        sticky_d[s] = 1'b0;
`else
                        gw_d[s] = GW_IDLE;
`endif
                    end
                end
                default:    gw_d[s] = GW_IDLE;
            endcase
`ifdef IRQ_GATEWAY_EDGE_EN
            // One edge seen while busy is remembered; later ones are dropped.
            if (gw_q[s] != GW_IDLE && trig[s] && !(gw_q[s] == GW_CLAIMED && cmpl_hit[s])) begin
                sticky_d[s] = 1'b1;
            end
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: priority and enable tables are reset because software expects them cleared after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                gw_q[s]   <= GW_IDLE;
                prio_q[s] <= '0;
            end
            for (int t = 0; t < NUM_TGT; t++) begin
                en_q[t]   <= '0;
                best_q[t] <= '0;
            end
            irq_q         <= '0;
            claim_valid_q <= '0;
            claim_id_q    <= '0;
`ifdef IRQ_GATEWAY_EDGE_EN
            src_prev_q    <= '0;
            sticky_q      <= '0;
`endif
        end else begin
            for (int s = 0; s < NUM_SRC; s++) begin
                gw_q[s] <= gw_d[s];
            end
            if (bus.prio_we_i) prio_q[bus.prio_idx_i] <= bus.prio_i;
            if (bus.en_we_i)   en_q[bus.en_tgt_i]     <= bus.en_mask_i;
            for (int t = 0; t < NUM_TGT; t++) begin
                best_q[t]                   <= best_d[t];
                irq_q[t]                    <= (best_d[t] != '0);
                claim_id_q[t*ID_W +: ID_W]  <= grant_id[t];
            end
            claim_valid_q <= bus.claim_req_i;
`ifdef IRQ_GATEWAY_EDGE_EN
            src_prev_q    <= bus.irq_src_i;
            sticky_q      <= sticky_d;
`endif
        end
    end

    assign bus.irq_o         = irq_q;
    assign bus.claim_valid_o = claim_valid_q;
    assign bus.claim_id_o    = claim_id_q;
endmodule

// File: tb/tb_irq_gateway_arbiter.sv
// Directed self-checking bench for irq_gateway_arbiter (16 sources, 3-bit priority, 2 targets).
// Edge-mode-only steps are enabled when IRQ_GATEWAY_EDGE_EN is defined.
module tb_irq_gateway_arbiter;
    localparam int NUM_SRC = 16;
    localparam int PRIO_W  = 3;
    localparam int NUM_TGT = 2;
    localparam int ID_W    = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    irq_gateway_arbiter_if #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W), .NUM_TGT(NUM_TGT)) bus ();

    irq_gateway_arbiter #(.NUM_SRC(NUM_SRC), .PRIO_W(PRIO_W), .NUM_TGT(NUM_TGT)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [ID_W-1:0] id_of(input int t);
        return bus.claim_id_o[t*ID_W +: ID_W];
    endfunction

    task automatic wr_prio(input int idx, input int p);
        bus.prio_we_i  = 1'b1;
        bus.prio_idx_i = 4'(idx);
        bus.prio_i     = 3'(p);
        tick();
        bus.prio_we_i  = 1'b0;
    endtask

    task automatic wr_en(input int t, input logic [15:0] mask);
        bus.en_we_i   = 1'b1;
        bus.en_tgt_i  = 1'(t);
        bus.en_mask_i = mask;
        tick();
        bus.en_we_i   = 1'b0;
    endtask

    task automatic claim(input logic [1:0] req);
        bus.claim_req_i = req;
        tick();
        bus.claim_req_i = '0;
    endtask

    task automatic complete(input int id);
        bus.cmpl_valid_i = 1'b1;
        bus.cmpl_id_i    = 5'(id);
        tick();
        bus.cmpl_valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.irq_src_i    = '0;
        bus.prio_we_i    = 1'b0;
        bus.prio_idx_i   = '0;
        bus.prio_i       = '0;
        bus.en_we_i      = 1'b0;
        bus.en_tgt_i     = '0;
        bus.en_mask_i    = '0;
        bus.thresh_i     = '0;
        bus.claim_req_i  = '0;
        bus.cmpl_valid_i = 1'b0;
        bus.cmpl_id_i    = '0;

        // 1: reset state and an empty claim
        tick(2);
        check("rst_irq", bus.irq_o, 2'b00);
        check("rst_valid", bus.claim_valid_o, 2'b00);
        check("rst_id", bus.claim_id_o, 10'h0);
        rst_n = 1'b1;
        tick(2);
        check("idle_irq", bus.irq_o, 2'b00);
        claim(2'b01);
        check("empty_claim_valid", bus.claim_valid_o, 2'b01);
        check("empty_claim_id", id_of(0), 5'd0);
        tick();
        check("claim_valid_one_cycle", bus.claim_valid_o, 2'b00);

        // 2: basic latency and claim of ID 5
        wr_prio(4, 3);
        wr_en(0, 16'hFFFF);
        bus.thresh_i = {3'd1, 3'd1};
        bus.irq_src_i[4] = 1'b1;
        tick();
        check("lat_edge_n", bus.irq_o[0], 1'b0);
        tick();
        check("lat_edge_n1", bus.irq_o[0], 1'b1);
        bus.irq_src_i[4] = 1'b0;
        tick();
        check("pending_latched", bus.irq_o[0], 1'b1);
        claim(2'b01);
        check("claim5_valid", bus.claim_valid_o, 2'b01);
        check("claim5_id", id_of(0), 5'd5);
        check("claim5_irq_drop", bus.irq_o[0], 1'b0);
        complete(5);
        tick();
        check("after_cmpl5_irq", bus.irq_o[0], 1'b0);

        // 3: equal priorities tie to lowest ID, then higher priority wins
        wr_prio(2, 5);
        wr_prio(7, 5);
        bus.irq_src_i[2] = 1'b1;
        bus.irq_src_i[7] = 1'b1;
        tick();
        bus.irq_src_i[2] = 1'b0;
        bus.irq_src_i[7] = 1'b0;
        tick();
        claim(2'b01);
        check("tie_first", id_of(0), 5'd3);
        claim(2'b01);
        check("tie_second", id_of(0), 5'd8);
        complete(3);
        complete(8);
        wr_prio(7, 6);
        bus.irq_src_i[2] = 1'b1;
        bus.irq_src_i[7] = 1'b1;
        tick();
        bus.irq_src_i[2] = 1'b0;
        bus.irq_src_i[7] = 1'b0;
        tick();
        claim(2'b01);
        check("prio_first", id_of(0), 5'd8);
        claim(2'b01);
        check("prio_second", id_of(0), 5'd3);
        complete(8);
        complete(3);

        // 4: threshold equal to priority blocks; lowering it releases
        bus.thresh_i = {3'd1, 3'd5};
        wr_prio(1, 5);
        bus.irq_src_i[1] = 1'b1;
        tick();
        bus.irq_src_i[1] = 1'b0;
        tick(2);
        check("thresh_block", bus.irq_o[0], 1'b0);
        bus.thresh_i = {3'd1, 3'd4};
        tick(2);
        check("thresh_release", bus.irq_o[0], 1'b1);
        claim(2'b01);
        check("thresh_claim", id_of(0), 5'd2);
        complete(2);
        bus.thresh_i = {3'd1, 3'd1};

        // 5: completion with source still high, and a bogus completion
        bus.irq_src_i[4] = 1'b1;
        tick(2);
        check("hold_irq", bus.irq_o[0], 1'b1);
        claim(2'b01);
        check("hold_claim", id_of(0), 5'd5);
        complete(9);
        tick();
        check("bogus_cmpl", bus.irq_o[0], 1'b0);
        complete(5);
        check("cmpl_irq_low", bus.irq_o[0], 1'b0);
        tick(2);
`ifdef IRQ_GATEWAY_EDGE_EN
        check("no_level_repend", bus.irq_o[0], 1'b0);
        bus.irq_src_i[4] = 1'b0;
`else
        check("level_repend", bus.irq_o[0], 1'b1);
        claim(2'b01);
        check("repend_claim", id_of(0), 5'd5);
        bus.irq_src_i[4] = 1'b0;
        complete(5);
`endif
        tick();

        // 6: simultaneous claims on the same ID
        wr_en(1, 16'hFFFF);
        bus.irq_src_i[4] = 1'b1;
        tick();
        bus.irq_src_i[4] = 1'b0;
        tick();
        check("both_irq", bus.irq_o, 2'b11);
        claim(2'b11);
        check("dual_valid", bus.claim_valid_o, 2'b11);
        check("dual_id_t0", id_of(0), 5'd5);
        check("dual_id_t1", id_of(1), 5'd0);
        check("dual_irq_drop", bus.irq_o, 2'b00);
        complete(5);
`ifdef IRQ_GATEWAY_EDGE_EN
        bus.irq_src_i[4] = 1'b1;
        tick();
        bus.irq_src_i[4] = 1'b0;
        tick();
        claim(2'b01);
        check("edge_claim", id_of(0), 5'd5);
        for (int i = 0; i < 2; i++) begin
            bus.irq_src_i[4] = 1'b1;
            tick();
            bus.irq_src_i[4] = 1'b0;
            tick();
        end
        check("edge_held", bus.irq_o, 2'b00);
        complete(5);
        tick();
        check("edge_sticky_repend", bus.irq_o, 2'b11);
        claim(2'b01);
        check("edge_sticky_claim", id_of(0), 5'd5);
        complete(5);
        tick(2);
        check("edge_single_repend", bus.irq_o, 2'b00);
`endif

        // priority dropped to zero keeps the source pending but ineligible
        bus.irq_src_i[4] = 1'b1;
        tick();
        bus.irq_src_i[4] = 1'b0;
        wr_prio(4, 0);
        tick();
        check("prio0_inelig", bus.irq_o, 2'b00);
        wr_prio(4, 3);
        tick();
        check("prio_restore", bus.irq_o, 2'b11);
        claim(2'b10);
        check("t1_claim", id_of(1), 5'd5);
        complete(5);

        // asynchronous reset in the middle of a claim
        bus.irq_src_i[4] = 1'b1;
        tick();
        bus.irq_src_i[4] = 1'b0;
        tick();
        bus.claim_req_i = 2'b01;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_irq", bus.irq_o, 2'b00);
        tick();
        bus.claim_req_i = '0;
        check("async_rst_no_valid", bus.claim_valid_o, 2'b00);
        rst_n = 1'b1;
        tick(3);
        check("post_rst_irq", bus.irq_o, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
